// File: rtl/sram_periph_slave_if.sv
// CPU data-port bus as seen by the peripheral slave.
// The master drives the request; the slave returns registered read data.
interface sram_periph_slave_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_en,
    output data_sram_wen,
    output data_sram_addr,
    output data_sram_wdata,
    input  data_sram_rdata
  );

  modport slave (
    input  data_sram_en,
    input  data_sram_wen,
    input  data_sram_addr,
    input  data_sram_wdata,
    output data_sram_rdata
  );
endinterface

// File: rtl/sram_periph_slave.sv
// Memory-mapped peripheral slave: scratch RAM, LEDs, switches,
// free-running timer with compare interrupt, and an ID register.
module sram_periph_slave #(
  parameter logic [31:0] ID_VALUE = 32'h5A5A_0001,
  parameter logic [15:0] BASE_HI  = 16'hBFAF
) (
  input  logic                      clk,
  input  logic                      resetn,
  sram_periph_slave_if.slave        bus,
  input  logic [15:0]               switch,
  output logic [15:0]               led,
  output logic                      timer_int
);

  localparam logic [13:0] A_LED = 14'h3C00;
  localparam logic [13:0] A_SW  = 14'h3C01;
  localparam logic [13:0] A_TMR = 14'h3C02;
  localparam logic [13:0] A_CMP = 14'h3C03;
  localparam logic [13:0] A_INT = 14'h3C04;
  localparam logic [13:0] A_ID  = 14'h3C05;

  function automatic logic [31:0] be_merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  be
  );
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return r;
  endfunction

  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wen;
  logic [15:0] off;
  logic [7:0]  idx;
  logic        sel;
  logic        wr;
  logic        rd;
  logic        unused_addr_lsb;

  assign addr  = bus.data_sram_addr;
  assign wdata = bus.data_sram_wdata;
  assign wen   = bus.data_sram_wen;
  assign off   = addr[15:0];
  assign idx   = off[9:2];
  assign sel   = bus.data_sram_en && (addr[31:16] == BASE_HI);
  assign wr    = sel && (wen != 4'h0);
  assign rd    = sel && (wen == 4'h0);
  assign unused_addr_lsb = ^addr[1:0];

  logic hit_ram;
  logic hit_led;
  logic hit_sw;
  logic hit_tmr;
  logic hit_cmp;
  logic hit_int;
  logic hit_id;

  assign hit_ram = (off[15:10] == 6'b10_0000);
  assign hit_led = (off[15:2] == A_LED);
  assign hit_sw  = (off[15:2] == A_SW);
  assign hit_tmr = (off[15:2] == A_TMR);
  assign hit_cmp = (off[15:2] == A_CMP);
  assign hit_int = (off[15:2] == A_INT);
  assign hit_id  = (off[15:2] == A_ID);

  logic [31:0] mem [256];
  logic        ram_we;

  // Gate with resetn so an edge during reset can never land a write.
  assign ram_we = wr && hit_ram && resetn;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[idx] <= be_merge(mem[idx], wdata, wen);
    end
  end

  logic [31:0] rdata_q, rdata_d;
  logic [15:0] led_q,   led_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] cmp_q,   cmp_d;
  logic        en_q,    en_d;
  logic        pend_q,  pend_d;
  logic        int_q,   int_d;
  logic [15:0] sync1_q, sync1_d;
  logic [15:0] sync2_q, sync2_d;

  logic [31:0] led_m;
  logic [31:0] tmr_m;
  logic [31:0] cmp_m;
  logic [31:0] rd_mux;
  logic        int_wr;
  logic        w1c;
  logic        match;

  assign led_m  = be_merge({16'h0, led_q}, wdata, wen & 4'b0011);
  assign tmr_m  = be_merge(timer_q, wdata, wen);
  assign cmp_m  = be_merge(cmp_q, wdata, wen);
  assign int_wr = wr && hit_int && wen[0];
  assign w1c    = int_wr && wdata[1];
  assign match  = (timer_q == cmp_q);

  always_comb begin
    rd_mux = 32'h0;
    unique case (1'b1)
      hit_ram: rd_mux = mem[idx];
      hit_led: rd_mux = {16'h0, led_q};
      hit_sw:  rd_mux = {16'h0, sync2_q};
      hit_tmr: rd_mux = timer_q;
      hit_cmp: rd_mux = cmp_q;
      hit_int: rd_mux = {30'h0, pend_q, en_q};
      hit_id:  rd_mux = ID_VALUE;
      default: rd_mux = 32'h0;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    led_d   = led_q;
    timer_d = timer_q + 32'd1;
    cmp_d   = cmp_q;
    en_d    = en_q;
    pend_d  = pend_q;
    sync1_d = switch;
    sync2_d = sync1_q;
    if (rd) begin
      rdata_d = rd_mux;
    end
    if (wr) begin
      unique case (1'b1)
        hit_led: led_d   = led_m[15:0];
        hit_tmr: timer_d = tmr_m;
        hit_cmp: cmp_d   = cmp_m;
        default: ;
      endcase
    end
    if (int_wr) begin
      en_d = wdata[0];
    end
    if (w1c) begin
      pend_d = 1'b0;
    end
    // A match in the same cycle as a clear must not be lost.
    if (match) begin
      pend_d = 1'b1;
    end
    int_d = pend_d & en_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q <= 32'h0;
      led_q   <= 16'h0;
      timer_q <= 32'h0;
      cmp_q   <= 32'hFFFF_FFFF;
      en_q    <= 1'b0;
      pend_q  <= 1'b0;
      int_q   <= 1'b0;
      sync1_q <= 16'h0;
      sync2_q <= 16'h0;
    end else begin
      rdata_q <= rdata_d;
      led_q   <= led_d;
      timer_q <= timer_d;
      cmp_q   <= cmp_d;
      en_q    <= en_d;
      pend_q  <= pend_d;
      int_q   <= int_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign bus.data_sram_rdata = rdata_q;
  assign led                 = led_q;
  assign timer_int           = int_q;

endmodule

// File: tb/tb_sram_periph_slave.sv
// Randomized self-checking bench for sram_periph_slave.
// Expected values come from a bench-side address-map/timer model.
module tb_sram_periph_slave;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] sw = 16'h0;
  logic [15:0] led;
  logic        timer_int;

  sram_periph_slave_if bus_if();

  sram_periph_slave dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus_if),
    .switch    (sw),
    .led       (led),
    .timer_int (timer_int)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] BASE = 32'hBFAF_0000;
  localparam logic [31:0] R_LED = BASE | 32'hF000;
  localparam logic [31:0] R_SW  = BASE | 32'hF004;
  localparam logic [31:0] R_TMR = BASE | 32'hF008;
  localparam logic [31:0] R_CMP = BASE | 32'hF00C;
  localparam logic [31:0] R_INT = BASE | 32'hF010;
  localparam logic [31:0] R_ID  = BASE | 32'hF014;

  int total = 0;
  int bad = 0;

  task automatic bus(input logic en, input logic [3:0] wen,
                     input logic [31:0] addr, input logic [31:0] wd);
    bus_if.data_sram_en    = en;
    bus_if.data_sram_wen   = wen;
    bus_if.data_sram_addr  = addr;
    bus_if.data_sram_wdata = wd;
    @(posedge clk);
    #1;
    bus_if.data_sram_en  = 1'b0;
    bus_if.data_sram_wen = 4'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] be,
                    input logic [31:0] d);
    bus(1'b1, be, a, d);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus(1'b1, 4'h0, a, 32'h0);
    d = bus_if.data_sram_rdata;
  endtask

  task automatic idle(input int n);
    repeat (n) bus(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus_if.data_sram_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", bus_if.data_sram_rdata); end
    total++; if (led !== 16'h0) begin bad++; $display("FAIL rst_led got=%h exp=0", led); end
    total++; if (timer_int !== 1'b0) begin bad++; $display("FAIL rst_int got=%b exp=0", timer_int); end
    resetn = 1'b1;
    rd(R_TMR, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL rst_tmr0 got=%h exp=0", v); end
    rd(R_TMR, v);
    total++; if (v !== 32'h1) begin bad++; $display("FAIL rst_tmr1 got=%h exp=1", v); end
    rd(R_CMP, v);
    total++; if (v !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rst_cmp got=%h exp=ffffffff", v); end
    rd(R_INT, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL rst_intctrl got=%h exp=0", v); end
    rd(R_SW, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL rst_sw got=%h exp=0", v); end
  endtask

  task automatic test_ram_spec();
    logic [31:0] v;
    wr(BASE | 32'h8010, 4'hF, 32'h1234_5678);
    wr(BASE | 32'h8010, 4'b0010, 32'hFFFF_AAFF);
    rd(BASE | 32'h8010, v);
    total++; if (v !== 32'h1234_AA78) begin bad++; $display("FAIL ram_spec got=%h exp=1234aa78", v); end
  endtask

  task automatic test_ram_random();
    logic [31:0] model [16];
    logic [7:0]  idx [16];
    logic [31:0] v, d, a;
    logic [3:0]  be;
    int k;
    for (int i = 0; i < 16; i++) begin
      idx[i] = 8'(i * 16 + $urandom_range(0, 15));
      if (i == 0) idx[i] = 8'd0;
      if (i == 15) idx[i] = 8'd255;
      model[i] = $urandom;
      wr(BASE | 32'h8000 | {22'h0, idx[i], 2'b00}, 4'hF, model[i]);
    end
    for (int n = 0; n < 80; n++) begin
      k = $urandom_range(0, 15);
      a = BASE | 32'h8000 | {22'h0, idx[k], 2'b00} | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        be = 4'($urandom_range(1, 15));
        d = $urandom;
        wr(a, be, d);
        for (int b = 0; b < 4; b++)
          if (be[b]) model[k][8*b +: 8] = d[8*b +: 8];
      end else begin
        rd(a, v);
        total++; if (v !== model[k]) begin bad++; $display("FAIL ram_rand idx=%0d got=%h exp=%h", idx[k], v, model[k]); end
      end
    end
  endtask

  task automatic test_regs();
    logic [31:0] v, d;
    logic [15:0] led_m;
    logic [3:0]  be;
    wr(R_LED, 4'hF, 32'hFFFF_C3A5);
    total++; if (led !== 16'hC3A5) begin bad++; $display("FAIL led_pin got=%h exp=c3a5", led); end
    rd(R_LED, v);
    total++; if (v !== 32'h0000_C3A5) begin bad++; $display("FAIL led_rd got=%h exp=0000c3a5", v); end
    rd(BASE | 32'hF100, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL unmapped_f100 got=%h exp=0", v); end
    rd(BASE | 32'h8400, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL unmapped_8400 got=%h exp=0", v); end
    wr(R_ID, 4'hF, 32'h0);
    wr(R_SW, 4'hF, 32'hFFFF_FFFF);
    rd(R_ID, v);
    total++; if (v !== 32'h5A5A_0001) begin bad++; $display("FAIL id got=%h exp=5a5a0001", v); end
    wr(R_LED, 4'hF, 32'h0);
    wr(BASE ^ 32'h0001_0000 | 32'hF000, 4'hF, 32'h0000_1111);
    bus(1'b1, 4'h0, BASE ^ 32'h0001_0000 | 32'hF014, 32'h0);
    idle(1);
    total++; if (bus_if.data_sram_rdata !== 32'h5A5A_0001) begin bad++; $display("FAIL rdata_hold got=%h exp=5a5a0001", bus_if.data_sram_rdata); end
    total++; if (led !== 16'h0) begin bad++; $display("FAIL unsel_wr got=%h exp=0", led); end
    led_m = 16'h0;
    for (int n = 0; n < 10; n++) begin
      be = 4'($urandom_range(1, 15));
      d = $urandom;
      wr(R_LED, be, d);
      if (be[0]) led_m[7:0] = d[7:0];
      if (be[1]) led_m[15:8] = d[15:8];
      rd(R_LED, v);
      total++; if (v !== {16'h0, led_m}) begin bad++; $display("FAIL led_rand be=%h got=%h exp=%h", be, v, {16'h0, led_m}); end
    end
  endtask

  task automatic test_switch();
    logic [31:0] v;
    logic [15:0] old_v, new_v;
    old_v = sw;
    for (int n = 0; n < 4; n++) begin
      new_v = (n == 0) ? 16'h00F0 : 16'($urandom);
      sw = new_v;
      rd(R_SW, v);
      total++; if (v !== {16'h0, old_v}) begin bad++; $display("FAIL sw_c0 got=%h exp=%h", v, {16'h0, old_v}); end
      rd(R_SW, v);
      total++; if (v !== {16'h0, old_v}) begin bad++; $display("FAIL sw_c1 got=%h exp=%h", v, {16'h0, old_v}); end
      rd(R_SW, v);
      total++; if (v !== {16'h0, new_v}) begin bad++; $display("FAIL sw_c2 got=%h exp=%h", v, {16'h0, new_v}); end
      old_v = new_v;
    end
  endtask

  task automatic test_timer_int();
    logic [31:0] v;
    logic exp_i;
    wr(R_CMP, 4'hF, 32'd20);
    wr(R_INT, 4'h1, 32'h1);
    wr(R_TMR, 4'hF, 32'd10);
    // Timer equals 20 ten edges after the write; PEND lands one edge later.
    for (int k = 1; k <= 12; k++) begin
      idle(1);
      exp_i = (k >= 11);
      total++; if (timer_int !== exp_i) begin bad++; $display("FAIL int_rise k=%0d got=%b exp=%b", k, timer_int, exp_i); end
    end
    wr(R_INT, 4'h1, 32'h3);
    total++; if (timer_int !== 1'b0) begin bad++; $display("FAIL int_w1c got=%b exp=0", timer_int); end
    rd(R_INT, v);
    total++; if (v !== 32'h1) begin bad++; $display("FAIL intctrl_en got=%h exp=1", v); end
    wr(R_TMR, 4'hF, 32'd18);
    idle(3);
    total++; if (timer_int !== 1'b1) begin bad++; $display("FAIL int_rearm got=%b exp=1", timer_int); end
    wr(R_INT, 4'h1, 32'h0);
    total++; if (timer_int !== 1'b0) begin bad++; $display("FAIL int_en0 got=%b exp=0", timer_int); end
    wr(R_CMP, 4'hF, 32'hFFFF_FFFF);
    rd(R_INT, v);
    total++; if (v !== 32'h2) begin bad++; $display("FAIL pend_keep got=%h exp=2", v); end
    wr(R_INT, 4'h1, 32'h1);
    total++; if (timer_int !== 1'b1) begin bad++; $display("FAIL int_en1 got=%b exp=1", timer_int); end
    wr(R_INT, 4'h1, 32'h2);
    total++; if (timer_int !== 1'b0) begin bad++; $display("FAIL int_w1c2 got=%b exp=0", timer_int); end
    rd(R_INT, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL intctrl_clr got=%h exp=0", v); end
  endtask

  task automatic test_timer_wrap();
    logic [31:0] v, w, t;
    int d;
    wr(R_TMR, 4'hF, 32'hFFFF_FFFE);
    rd(R_TMR, v);
    total++; if (v !== 32'hFFFF_FFFE) begin bad++; $display("FAIL wrap0 got=%h exp=fffffffe", v); end
    rd(R_TMR, v);
    total++; if (v !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap1 got=%h exp=ffffffff", v); end
    rd(R_TMR, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL wrap2 got=%h exp=0", v); end
    for (int n = 0; n < 5; n++) begin
      w = $urandom;
      d = $urandom_range(0, 6);
      wr(R_TMR, 4'hF, w);
      idle(d);
      rd(R_TMR, v);
      total++; if (v !== w + 32'(d)) begin bad++; $display("FAIL tmr_rand d=%0d got=%h exp=%h", d, v, w + 32'(d)); end
    end
    t = 32'($urandom_range(1000, 32'h3FFF_FFFF));
    wr(R_TMR, 4'hF, 32'h0);
    wr(R_CMP, 4'hF, t + 32'd5);
    wr(R_INT, 4'h1, 32'h2);
    wr(R_TMR, 4'hF, t);
    idle(4);
    rd(R_INT, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL pre_match got=%h exp=0", v); end
    wr(R_INT, 4'h1, 32'h2);
    rd(R_INT, v);
    total++; if (v !== 32'h2) begin bad++; $display("FAIL set_wins got=%h exp=2", v); end
    wr(R_INT, 4'h1, 32'h2);
    rd(R_INT, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL late_w1c got=%h exp=0", v); end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] v;
    wr(R_LED, 4'hF, 32'h0000_1234);
    rd(R_ID, v);
    bus_if.data_sram_en    = 1'b1;
    bus_if.data_sram_wen   = 4'hF;
    bus_if.data_sram_addr  = R_LED;
    bus_if.data_sram_wdata = 32'h0000_5555;
    #2;
    resetn = 1'b0;
    #1;
    total++; if (led !== 16'h0) begin bad++; $display("FAIL midrst_led got=%h exp=0", led); end
    total++; if (bus_if.data_sram_rdata !== 32'h0) begin bad++; $display("FAIL midrst_rdata got=%h exp=0", bus_if.data_sram_rdata); end
    total++; if (timer_int !== 1'b0) begin bad++; $display("FAIL midrst_int got=%b exp=0", timer_int); end
    repeat (2) @(posedge clk);
    #1;
    total++; if (led !== 16'h0) begin bad++; $display("FAIL inrst_led got=%h exp=0", led); end
    bus_if.data_sram_en  = 1'b0;
    bus_if.data_sram_wen = 4'h0;
    resetn = 1'b1;
    rd(R_LED, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL postrst_led got=%h exp=0", v); end
    rd(R_TMR, v);
    total++; if (v !== 32'h1) begin bad++; $display("FAIL postrst_tmr got=%h exp=1", v); end
    wr(R_LED, 4'hF, 32'h0000_0077);
    total++; if (led !== 16'h0077) begin bad++; $display("FAIL postrst_wr got=%h exp=0077", led); end
  endtask

  initial begin
    bus_if.data_sram_en    = 1'b0;
    bus_if.data_sram_wen   = 4'h0;
    bus_if.data_sram_addr  = 32'h0;
    bus_if.data_sram_wdata = 32'h0;
    test_reset();
    test_ram_spec();
    test_ram_random();
    test_regs();
    test_switch();
    test_timer_int();
    test_timer_wrap();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_periph_slave.md
SRAM_PERIPH_SLAVE -- requirements
Module: sram_periph_slave

Interface
REQ-001 Parameter ID_VALUE, default 32'h5A5A_0001: constant returned by the ID register.
REQ-002 Parameter BASE_HI, default 16'hBFAF: data_sram_addr[31:16] value that selects this block.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 data_sram_en  input  1  access request from the CPU data port.
REQ-006 data_sram_wen  input  4  byte write enables; 4'b0000 with en=1 means read.
REQ-007 data_sram_addr  input  32  byte address; bits [1:0] ignored.
REQ-008 data_sram_wdata  input  32  write data, byte lane i = bits [8i+7:8i].
REQ-009 data_sram_rdata  output  32  read data, registered.
REQ-010 switch  input  16  asynchronous board switches.
REQ-011 led  output  16  LED register contents.
REQ-012 timer_int  output  1  level interrupt to CPU ext_int[0].

Function
REQ-013 Selected access: en=1 and addr[31:16]==BASE_HI; otherwise no state change from the bus.
REQ-014 Map by addr[15:0]: 0x8000-0x83FC scratch RAM (256x32); 0xF000 LED; 0xF004 SWITCH (RO); 0xF008 TIMER; 0xF00C COMPARE; 0xF010 INT_CTRL; 0xF014 ID (RO).
REQ-015 Any other offset is unmapped: reads return 0, writes ignored.
REQ-016 Writes honour byte enables on RAM, LED, TIMER, COMPARE; unselected bytes keep their value.
REQ-017 LED is 16 bits; only lanes 0-1 are writable; upper read bits are 0.
REQ-018 Reads have fixed 1-cycle latency: a read sampled at edge N drives rdata after edge N; a value written at edge N is readable via a read at edge N+1.
REQ-019 rdata updates only on a selected read; otherwise (write, idle, unselected) it holds its previous value.
REQ-020 Writes to RO registers (SWITCH, ID) are ignored without error.
REQ-021 switch passes through a 2-flop synchronizer; SWITCH reads {16'b0, synchronized value}.
REQ-022 TIMER is a 32-bit free-running counter, +1 every cycle, wrapping 0xFFFF_FFFF -> 0.
REQ-023 TIMER bus write takes priority over increment in that cycle; the next cycle counts from the written value.
REQ-024 INT_CTRL: bit0 EN (RW), bit1 PEND (read; write 1 clears), bits [31:2] read 0.
REQ-025 PEND sets in the cycle after the registered TIMER equals COMPARE, independent of EN.
REQ-026 Simultaneous PEND set and W1C: set wins.
REQ-027 timer_int = PEND & EN, driven from registers, glitch-free.
REQ-028 COMPARE write does not clear PEND.

Reset
REQ-029 On resetn=0, immediately: rdata=0, led=0, TIMER=0, COMPARE=0xFFFF_FFFF, EN=0, PEND=0, sync flops=0, timer_int=0.
REQ-030 Scratch RAM contents are not reset (undefined after reset).
REQ-031 Reset asserted mid-access aborts it; no partial write survives; first access after release behaves normally.

Verification
REQ-032 Write 0x1234_5678 with wen=4'hF to 0xBFAF_8010, then wen=4'b0010 with 0xFFFF_AAFF -> read returns 0x1234_AA78 one cycle after request.
REQ-033 Write LED 0xFFFF_C3A5 wen=4'hF -> led=16'hC3A5; LED read = 0x0000_C3A5; read 0xBFAF_F100 -> 0; read ID -> 0x5A5A_0001.
REQ-034 switch=16'h00F0 held -> SWITCH read returns 0x0000_00F0 once 2+ cycles have elapsed since the change; read within 1 cycle returns the old value.
REQ-035 COMPARE=20, EN=1, TIMER=10 -> PEND and timer_int rise 11 cycles after the TIMER write; W1C 0x2 to INT_CTRL -> timer_int=0 next cycle; EN=0 with PEND=1 -> timer_int=0.
REQ-036 TIMER=0xFFFF_FFFE -> reads show wrap to 0x0000_0000 two cycles later; W1C in same cycle as match -> PEND remains 1.
REQ-037 Assert resetn=0 asynchronously between edges during a write to LED -> led=0 and rdata=0 immediately; LED read after release = 0.
